// File: rtl/select_pkg.sv
// Shared access-size encodings and FSM state type for the data-memory responder.
package select_pkg;

    localparam logic [2:0] SEL_B  = 3'b000;
    localparam logic [2:0] SEL_H  = 3'b001;
    localparam logic [2:0] SEL_W  = 3'b010;
    localparam logic [2:0] SEL_BU = 3'b100;
    localparam logic [2:0] SEL_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WRITE,
        RESP
    } mem_state_t;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane logic: load extraction with sign/zero extension, and sub-word store merge.
module mem_lane
    import select_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  sel_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (sel_i)
            SEL_B:   load_o = {{24{byte_v[7]}}, byte_v};
            SEL_BU:  load_o = {24'd0, byte_v};
            SEL_H:   load_o = {{16{half_v[15]}}, half_v};
            SEL_HU:  load_o = {16'd0, half_v};
            default: load_o = word_i;
        endcase

        // Only the addressed lane is replaced; the rest of the word is kept.
        store_o = word_i;
        case (sel_i[1:0])
            2'b00: store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            2'b01: begin
                if (off_i[1]) store_o[31:16] = wdata_i[15:0];
                else          store_o[15:0]  = wdata_i[15:0];
            end
            default: store_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: single-port synchronous RAM serving one aligned load/store at a time.
module data_mem_resp
    import select_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  sel_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_t    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merged_q, merged_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   ram_q;
    logic [31:0]   load_val, store_val;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic          illegal;

    logic [31:0] mem [DEPTH];

    always_comb begin
        illegal = 1'b0;
        case (sel_type)
            SEL_B:   illegal = 1'b0;
            SEL_H:   illegal = addr[0];
            SEL_W:   illegal = (addr[1:0] != 2'b00);
            SEL_BU:  illegal = we;
            SEL_HU:  illegal = we | addr[0];
            default: illegal = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= 32'(DEPTH)) illegal = 1'b1;
    end

    mem_lane u_lane (
        .word_i  (ram_q),
        .wdata_i (wdata_q),
        .off_i   (off_q),
        .sel_i   (sel_q),
        .load_o  (load_val),
        .store_o (store_val)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        off_d    = off_q;
        sel_d    = sel_q;
        we_d     = we_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = addr[AW+1:2];
                    off_d   = addr[1:0];
                    sel_d   = sel_type;
                    we_d    = we;
                    wdata_d = wdata;
                    err_d   = illegal;
                    if (illegal)                     state_d = RESP;
                    else if (we && sel_type == SEL_W) state_d = WRITE;
                    else                             state_d = READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                if (we_q) begin
                    merged_d = store_val;
                    state_d  = WRITE;
                end else begin
                    rdata_d  = load_val;
                    state_d  = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q    <= idx_d;
        off_q    <= off_d;
        sel_q    <= sel_d;
        we_q     <= we_d;
        wdata_q  <= wdata_d;
        merged_q <= merged_d;
    end

    // A reset on the edge leaving WRITE must leave the RAM untouched.
    assign ram_we    = (state_q == WRITE) && !rst;
    assign ram_wdata = (sel_q == SEL_W) ? wdata_q : merged_q;

    always_ff @(posedge clk) begin
        if (ram_we) mem[idx_q] <= ram_wdata;
        if (state_q == READ) ram_q <= mem[idx_q];
    end

    assign ready = (state_q == RESP);
    assign err   = (state_q == RESP) && err_q;
    assign busy  = (state_q != IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: directed accesses, latency, error, busy and reset cases.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  sel_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [31:0] last_rd = 32'd0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        er;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    data_mem_resp #(.DEPTH(1024), .INIT_FILE("")) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .sel_type (sel_type),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every ready pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (err && !ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL err_without_ready: err=%0b ready=%0b", err, ready);
        end
        if (ready) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got ready=1 rdata=%08h err=%0b, expected none", rdata, err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (err !== e.er || rdata !== e.rd || (cyc - e.issue) != e.lat) begin
                    n_fail++;
                    $display("FAIL %s: got rdata=%08h err=%0b lat=%0d, expected rdata=%08h err=%0b lat=%0d",
                             e.name, rdata, err, cyc - e.issue, e.rd, e.er, e.lat);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", nm, got, exp);
        end
    endtask

    task automatic wait_done(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            if (sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no ready within 10 cycles, expected one", nm);
            void'(sb_q.pop_front());
        end
        @(negedge clk);
        #1;
        check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic access(input string nm, input logic w, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_er, input int lat);
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = w; sel_type = s; addr = a; wdata = d;
        if (!w && !exp_er) last_rd = exp_rd;
        e.name = nm; e.rd = last_rd; e.er = exp_er; e.issue = cyc; e.lat = lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble the request fields: the DUT must have latched them.
        req = 1'b0; we = ~w; sel_type = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
        wait_done(nm);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; sel_type = 3'b010; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err",   {31'd0, err},   32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        rst = 1'b0;

        access("sw_10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        access("lw_10",   1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        access("sw_10b",  1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, 2);
        access("sb_13",   1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 4);
        access("lw_sb",   1'b0, 3'b010, 32'h10, 32'h0, 32'hA5223344, 1'b0, 3);
        access("sh_10",   1'b1, 3'b001, 32'h10, 32'h00008001, 32'h0, 1'b0, 4);
        access("lw_sh",   1'b0, 3'b010, 32'h10, 32'h0, 32'hA5228001, 1'b0, 3);

        access("sw_20",   1'b1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, 2);
        access("lb_20",   1'b0, 3'b000, 32'h20, 32'h0, 32'h00000001, 1'b0, 3);
        access("lb_22",   1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 3);
        access("lbu_22",  1'b0, 3'b100, 32'h22, 32'h0, 32'h000000FF, 1'b0, 3);
        access("lh_22",   1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 3);
        access("lhu_22",  1'b0, 3'b101, 32'h22, 32'h0, 32'h000080FF, 1'b0, 3);
        access("lb_21",   1'b0, 3'b000, 32'h21, 32'h0, 32'h0000007F, 1'b0, 3);

        access("err_lw21",  1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1, 1);
        access("err_sh23",  1'b1, 3'b001, 32'h23, 32'h0000BEEF, 32'h0, 1'b1, 1);
        access("lw_20_chk", 1'b0, 3'b010, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 3);
        access("err_depth", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
        access("err_sel7",  1'b0, 3'b111, 32'h20, 32'h0, 32'h0, 1'b1, 1);
        access("err_sbu",   1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 1'b1, 1);
        access("lw_20_chk2",1'b0, 3'b010, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 3);

        // Extra req pulses in READ, EXEC and RESP must not start new accesses.
        begin
            exp_t e;
            @(negedge clk);
            req = 1'b1; we = 1'b0; sel_type = 3'b010; addr = 32'h10; wdata = 32'd0;
            last_rd = 32'hA5228001;
            e.name = "busy_lw"; e.rd = last_rd; e.er = 1'b0; e.issue = cyc; e.lat = 3;
            sb_q.push_back(e);
            @(posedge clk); #1 req = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                req = 1'b1;
                @(posedge clk); #1 req = 1'b0;
            end
            @(negedge clk); #1;
            check("busy_fall", {31'd0, busy}, 32'd0);
            repeat (5) @(negedge clk);
            check("busy_queue_empty", 32'(sb_q.size()), 32'd0);
        end

        access("sw_30", 1'b1, 3'b010, 32'h30, 32'h12345678, 32'h0, 1'b0, 2);
        @(negedge clk);
        req = 1'b1; we = 1'b1; sel_type = 3'b000; addr = 32'h30; wdata = 32'h000000EE;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_err",   {31'd0, err},   32'd0);
        check("midrst_busy",  {31'd0, busy},  32'd0);
        last_rd = 32'd0;
        access("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 32'h12345678, 1'b0, 3);

        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
